// File: rtl/exec_unit.sv
// Execute-side responder for the control unit: holds AC/E, runs register- and
// memory-reference ops, and answers each accepted op with a one-cycle o_ex_done.
module exec_unit #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_execute,
  input  logic [11:0] i_op,
  input  logic [11:0] i_addr,
  input  logic [7:0]  i_imm,
  output logic [11:0] o_mem_addr,
  output logic        o_mem_ce,
  output logic        o_mem_we,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  output logic [15:0] o_ac,
  output logic        o_e,
  output logic        o_ex_done,
  output logic        o_pc_load,
  output logic [11:0] o_pc_target,
  output logic        o_skip,
  output logic        o_err,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Register-reference ops are kept as i_op[11:5]; indices below are into that field.
  localparam int R_CLA = 0;
  localparam int R_CLE = 1;
  localparam int R_CMA = 2;
  localparam int R_LDI = 3;
  localparam int R_CIR = 4;
  localparam int R_CIL = 5;
  localparam int R_INC = 6;
  localparam int CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t         state_q;
  logic           exec_q;
  logic           armed_q;
  logic [6:0]     rop_q;
  logic           add_q;
  logic           lda_q;
  logic           isz_q;
  logic [11:0]    addr_q;
  logic [7:0]     imm_q;
  logic [15:0]    ac_q;
  logic           e_q;
  logic [CW-1:0]  wait_q;
  logic           mem_ce_q;
  logic           mem_we_q;
  logic [15:0]    mem_wdata_q;
  logic           done_q;
  logic           pc_load_q;
  logic           skip_q;
  logic           err_q;

  logic           start;
  logic           op_onehot;
  logic           op_mem_rd;
  logic [15:0]    rdata_inc;

  // Handshake: i_execute is a level request; one op is accepted per rising edge
  // seen while IDLE, and exactly one o_ex_done pulse answers it. A level already
  // high when reset is released is not an edge: armed_q waits for it to drop.
  assign start     = (state_q == IDLE) && i_execute && !exec_q && armed_q;
  assign op_onehot = (i_op != 12'd0) && ((i_op & (i_op - 12'd1)) == 12'd0);
  assign op_mem_rd = i_op[0] | i_op[1] | i_op[4];
  assign rdata_inc = i_mem_rdata + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      exec_q      <= 1'b0;
      armed_q     <= 1'b0;
      rop_q       <= '0;
      add_q       <= 1'b0;
      lda_q       <= 1'b0;
      isz_q       <= 1'b0;
      addr_q      <= '0;
      imm_q       <= '0;
      ac_q        <= '0;
      e_q         <= 1'b0;
      wait_q      <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      pc_load_q   <= 1'b0;
      skip_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      exec_q    <= i_execute;
      armed_q   <= armed_q | ~i_execute;
      mem_ce_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rop_q  <= i_op[11:5];
            add_q  <= i_op[0];
            lda_q  <= i_op[1];
            isz_q  <= i_op[4];
            addr_q <= i_addr;
            imm_q  <= i_imm;
            if (!op_onehot) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (i_op[3]) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              pc_load_q <= 1'b1;
            end else if (i_op[2]) begin
              state_q     <= WR;
              mem_ce_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= ac_q;
            end else if (op_mem_rd) begin
              state_q  <= RD_REQ;
              mem_ce_q <= 1'b1;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          if (rop_q[R_CLA]) begin
            ac_q <= '0;
          end else if (rop_q[R_CLE]) begin
            e_q <= 1'b0;
          end else if (rop_q[R_CMA]) begin
            ac_q <= ~ac_q;
          end else if (rop_q[R_LDI]) begin
            ac_q <= {8'h00, imm_q};
          end else if (rop_q[R_CIR]) begin
            ac_q <= {e_q, ac_q[15:1]};
            e_q  <= ac_q[0];
          end else if (rop_q[R_CIL]) begin
            ac_q <= {ac_q[14:0], e_q};
            e_q  <= ac_q[15];
          end else if (rop_q[R_INC]) begin
            ac_q <= ac_q + 16'd1;
          end
        end
        RD_REQ: begin
          state_q <= RD_WAIT;
          wait_q  <= CW'(RD_LAT - 1);
        end
        RD_WAIT: begin
          // Read data is valid only in the last wait cycle.
          if (wait_q == '0) begin
            if (isz_q) begin
              state_q     <= WR;
              mem_ce_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= rdata_inc;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              if (add_q) begin
                {e_q, ac_q} <= {1'b0, ac_q} + {1'b0, i_mem_rdata};
              end else if (lda_q) begin
                ac_q <= i_mem_rdata;
              end
            end
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        WR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          skip_q  <= isz_q && (mem_wdata_q == 16'd0);
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_ce    = mem_ce_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_ac        = ac_q;
  assign o_e         = e_q;
  assign o_ex_done   = done_q;
  assign o_pc_load   = pc_load_q;
  assign o_pc_target = addr_q;
  assign o_skip      = skip_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: two instances (read latency 1 and 2) run the same op
// sequence; a reference model predicts every result into per-instance queues.
module tb_exec_unit;

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_LDA = 12'h002;
  localparam logic [11:0] OP_STA = 12'h004;
  localparam logic [11:0] OP_BUN = 12'h008;
  localparam logic [11:0] OP_ISZ = 12'h010;
  localparam logic [11:0] OP_CLA = 12'h020;
  localparam logic [11:0] OP_CLE = 12'h040;
  localparam logic [11:0] OP_CMA = 12'h080;
  localparam logic [11:0] OP_LDI = 12'h100;
  localparam logic [11:0] OP_CIR = 12'h200;
  localparam logic [11:0] OP_CIL = 12'h400;
  localparam logic [11:0] OP_INC = 12'h800;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_execute;
  logic [11:0] i_op;
  logic [11:0] i_addr;
  logic [7:0]  i_imm;
  logic [11:0] mem_addr  [2];
  logic        mem_ce    [2];
  logic        mem_we    [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic [15:0] ac        [2];
  logic        e_bit     [2];
  logic        ex_done   [2];
  logic        pc_load   [2];
  logic [11:0] pc_target [2];
  logic        skip      [2];
  logic        err       [2];
  logic [2:0]  dbg       [2];

  exec_unit #(.RD_LAT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .i_execute(i_execute), .i_op(i_op),
    .i_addr(i_addr), .i_imm(i_imm), .o_mem_addr(mem_addr[0]), .o_mem_ce(mem_ce[0]),
    .o_mem_we(mem_we[0]), .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]),
    .o_ac(ac[0]), .o_e(e_bit[0]), .o_ex_done(ex_done[0]), .o_pc_load(pc_load[0]),
    .o_pc_target(pc_target[0]), .o_skip(skip[0]), .o_err(err[0]), .o_dbg_state(dbg[0])
  );

  exec_unit #(.RD_LAT(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .i_execute(i_execute), .i_op(i_op),
    .i_addr(i_addr), .i_imm(i_imm), .o_mem_addr(mem_addr[1]), .o_mem_ce(mem_ce[1]),
    .o_mem_we(mem_we[1]), .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]),
    .o_ac(ac[1]), .o_e(e_bit[1]), .o_ex_done(ex_done[1]), .o_pc_load(pc_load[1]),
    .o_pc_target(pc_target[1]), .o_skip(skip[1]), .o_err(err[1]), .o_dbg_state(dbg[1])
  );

  // RAM models; an unread cycle returns 16'hDEAD so early/late sampling shows up
  logic [15:0] ram     [2][4096];
  logic [15:0] rd_pipe [2][2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_ce[d] && mem_we[d]) ram[d][mem_addr[d]] <= mem_wdata[d];
      rd_pipe[d][0] <= (mem_ce[d] && !mem_we[d]) ? ram[d][mem_addr[d]] : 16'hDEAD;
      rd_pipe[d][1] <= rd_pipe[d][0];
    end
  end
  assign mem_rdata[0] = rd_pipe[0][0];
  assign mem_rdata[1] = rd_pipe[1][1];

  // monitor: records DUT events, sampled on the falling edge
  int          done_cnt [2];
  int          done_cyc [2];
  logic [15:0] done_ac  [2];
  logic        done_e   [2];
  logic        done_pl  [2];
  logic        done_sk  [2];
  logic        done_err [2];
  logic [11:0] done_tgt [2];
  int          ce_cnt   [2];
  int          rd_cyc   [2];
  logic [11:0] rd_addr  [2];
  int          wr_cyc   [2];
  logic [11:0] wr_addr  [2];
  logic [15:0] wr_data  [2];
  int          bad_cnt  [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ex_done[d]) begin
        done_cnt[d] <= done_cnt[d] + 1;
        done_cyc[d] <= cyc;
        done_ac[d]  <= ac[d];
        done_e[d]   <= e_bit[d];
        done_pl[d]  <= pc_load[d];
        done_sk[d]  <= skip[d];
        done_err[d] <= err[d];
        done_tgt[d] <= pc_target[d];
      end
      if (mem_ce[d]) begin
        ce_cnt[d] <= ce_cnt[d] + 1;
        if (mem_we[d]) begin
          wr_cyc[d]  <= cyc;
          wr_addr[d] <= mem_addr[d];
          wr_data[d] <= mem_wdata[d];
        end else begin
          rd_cyc[d]  <= cyc;
          rd_addr[d] <= mem_addr[d];
        end
      end
      if ((!ex_done[d] && (pc_load[d] || skip[d] || err[d])) ||
          (mem_ce[d] && dbg[d] != 3'd2 && dbg[d] != 3'd4))
        bad_cnt[d] <= bad_cnt[d] + 1;
    end
  end

  // scoreboard: {done cycle, ac, e, pc_load, skip, err, target}
  logic [63:0] exp0_q[$];
  logic [63:0] exp1_q[$];
  int          chk_cnt = 0;
  int          err_cnt = 0;
  int          n_issued = 0;
  logic [15:0] m_ac;
  logic        m_e;
  logic [15:0] mm [4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input logic [15:0] exp_ac, input logic exp_e);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s ac d%0d", tag, d), ac[d], exp_ac);
      chk($sformatf("%s e d%0d", tag, d), e_bit[d], exp_e);
    end
  endtask

  // driver: issue one op, predict its outcome, wait for both instances, compare
  task automatic issue(input logic [11:0] op, input logic [11:0] addr, input logic [7:0] imm);
    logic [15:0] nac, m, mi, wexp;
    logic        ne, pl, sk, er, rd, wr;
    int          off, acc, lat, wcyc;
    int          tgt[2], ce0[2];
    logic [63:0] ev;
    @(negedge clk);
    nac = m_ac; ne = m_e; pl = 1'b0; sk = 1'b0; er = 1'b0; rd = 1'b0; wr = 1'b0;
    m = mm[addr]; mi = m + 16'd1; wexp = 16'd0; off = 2; wcyc = 0;
    if (op == 12'd0 || (op & (op - 12'd1)) != 12'd0) begin
      er = 1'b1; off = 1;
    end else if (op == OP_ADD) begin
      {ne, nac} = {1'b0, m_ac} + {1'b0, m}; rd = 1'b1;
    end else if (op == OP_LDA) begin
      nac = m; rd = 1'b1;
    end else if (op == OP_STA) begin
      wr = 1'b1; wexp = m_ac; mm[addr] = m_ac;
    end else if (op == OP_BUN) begin
      pl = 1'b1; off = 1;
    end else if (op == OP_ISZ) begin
      rd = 1'b1; wr = 1'b1; wexp = mi; sk = (mi == 16'd0); mm[addr] = mi; off = 3;
    end else if (op == OP_CLA) nac = 16'd0;
    else if (op == OP_CLE) ne = 1'b0;
    else if (op == OP_CMA) nac = ~m_ac;
    else if (op == OP_LDI) nac = {8'h00, imm};
    else if (op == OP_CIR) begin
      nac = {m_e, m_ac[15:1]}; ne = m_ac[0];
    end else if (op == OP_CIL) begin
      nac = {m_ac[14:0], m_e}; ne = m_ac[15];
    end else if (op == OP_INC) nac = m_ac + 16'd1;
    acc = cyc;
    for (int d = 0; d < 2; d++) begin
      tgt[d] = done_cnt[d] + 1;
      ce0[d] = ce_cnt[d];
    end
    exp0_q.push_back({32'(acc + off + (rd ? 1 : 0)), nac, ne, pl, sk, er, addr});
    exp1_q.push_back({32'(acc + off + (rd ? 2 : 0)), nac, ne, pl, sk, er, addr});
    n_issued++;
    i_execute = 1'b1; i_op = op; i_addr = addr; i_imm = imm;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done_cnt[0] >= tgt[0] && done_cnt[1] >= tgt[1]) break;
    end
    @(negedge clk);
    i_execute = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lat = d + 1;
      chk($sformatf("op%03h done_seen d%0d", op, d), done_cnt[d], tgt[d]);
      if (d == 0) ev = exp0_q.pop_front();
      else        ev = exp1_q.pop_front();
      chk($sformatf("op%03h done_cyc d%0d", op, d), done_cyc[d], ev[63:32]);
      chk($sformatf("op%03h ac d%0d", op, d), done_ac[d], ev[31:16]);
      chk($sformatf("op%03h e d%0d", op, d), done_e[d], ev[15]);
      chk($sformatf("op%03h pc_load d%0d", op, d), done_pl[d], ev[14]);
      chk($sformatf("op%03h skip d%0d", op, d), done_sk[d], ev[13]);
      chk($sformatf("op%03h err d%0d", op, d), done_err[d], ev[12]);
      if (ev[14]) chk($sformatf("op%03h target d%0d", op, d), done_tgt[d], ev[11:0]);
      chk($sformatf("op%03h ce_count d%0d", op, d), ce_cnt[d] - ce0[d],
          (rd ? 1 : 0) + (wr ? 1 : 0));
      if (rd) begin
        chk($sformatf("op%03h rd_cyc d%0d", op, d), rd_cyc[d], acc + 1);
        chk($sformatf("op%03h rd_addr d%0d", op, d), rd_addr[d], addr);
      end
      if (wr) begin
        wcyc = (op == OP_ISZ) ? acc + 2 + lat : acc + 1;
        chk($sformatf("op%03h wr_cyc d%0d", op, d), wr_cyc[d], wcyc);
        chk($sformatf("op%03h wr_addr d%0d", op, d), wr_addr[d], addr);
        chk($sformatf("op%03h wr_data d%0d", op, d), wr_data[d], wexp);
      end
    end
    m_ac = nac;
    m_e  = ne;
  endtask

  initial begin
    m_ac = 16'd0; m_e = 1'b0;
    // reset with i_execute held high: no accept until it falls and rises again
    reset_n = 1'b0; i_execute = 1'b1; i_op = OP_CLA; i_addr = 12'd0; i_imm = 8'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst ac d%0d", d), ac[d], 16'd0);
      chk($sformatf("rst e d%0d", d), e_bit[d], 1'b0);
      chk($sformatf("rst ce d%0d", d), mem_ce[d], 1'b0);
      chk($sformatf("rst done d%0d", d), ex_done[d], 1'b0);
      chk($sformatf("rst flags d%0d", d), {pc_load[d], skip[d], err[d]}, 3'b000);
      chk($sformatf("rst state d%0d", d), dbg[d], 3'd0);
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("held_exec done_cnt d%0d", d), done_cnt[d], 0);
      chk($sformatf("held_exec state d%0d", d), dbg[d], 3'd0);
      chk($sformatf("held_exec ce_cnt d%0d", d), ce_cnt[d], 0);
    end
    i_execute = 1'b0;

    // rotates through E
    issue(OP_LDI, 12'd0, 8'h00);
    issue(OP_CMA, 12'd0, 8'h00);
    issue(OP_CIL, 12'd0, 8'h00);
    chk_acc("cil_ffff", 16'hFFFE, 1'b1);
    issue(OP_LDI, 12'd0, 8'hFF);
    chk_acc("ldi_ff", 16'h00FF, 1'b1);
    issue(OP_CIR, 12'd0, 8'h00);
    chk_acc("cir", 16'h807F, 1'b1);
    issue(OP_CIL, 12'd0, 8'h00);
    chk_acc("cil", 16'h00FF, 1'b1);

    // ADD with carry-out
    issue(OP_LDI, 12'd0, 8'h00);
    issue(OP_CMA, 12'd0, 8'h00);
    issue(OP_STA, 12'h010, 8'h00);
    issue(OP_LDI, 12'd0, 8'h01);
    issue(OP_CLE, 12'd0, 8'h00);
    issue(OP_ADD, 12'h010, 8'h00);
    chk_acc("add_carry", 16'h0000, 1'b1);

    // build 0x1234, store it, read it back
    issue(OP_LDI, 12'd0, 8'h34);
    issue(OP_STA, 12'h030, 8'h00);
    issue(OP_CLE, 12'd0, 8'h00);
    issue(OP_LDI, 12'd0, 8'h12);
    for (int i = 0; i < 8; i++) issue(OP_CIL, 12'd0, 8'h00);
    issue(OP_ADD, 12'h030, 8'h00);
    chk_acc("build", 16'h1234, 1'b0);
    issue(OP_STA, 12'h0AB, 8'h00);
    issue(OP_CLA, 12'd0, 8'h00);
    issue(OP_LDA, 12'h0AB, 8'h00);
    chk_acc("lda_back", 16'h1234, 1'b0);

    // ISZ wrap to zero then increment without skip
    issue(OP_LDI, 12'd0, 8'h00);
    issue(OP_CMA, 12'd0, 8'h00);
    issue(OP_STA, 12'h020, 8'h00);
    issue(OP_ISZ, 12'h020, 8'h00);
    issue(OP_ISZ, 12'h020, 8'h00);

    // errors, branch, INC wrap
    issue(OP_LDI, 12'd0, 8'h5A);
    issue(12'h003, 12'h010, 8'h00);
    issue(12'h000, 12'h010, 8'h00);
    issue(12'hC00, 12'h010, 8'h00);
    chk_acc("err_keep", 16'h005A, 1'b0);
    issue(OP_BUN, 12'h5A5, 8'h00);
    issue(OP_LDI, 12'd0, 8'h00);
    issue(OP_CMA, 12'd0, 8'h00);
    issue(OP_INC, 12'd0, 8'h00);
    chk_acc("inc_wrap", 16'h0000, 1'b0);

    // reset while both instances sit in RD_WAIT
    issue(OP_LDI, 12'd0, 8'h77);
    @(negedge clk);
    i_execute = 1'b1; i_op = OP_LDA; i_addr = 12'h0AB;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("pre_abort state d%0d", d), dbg[d], 3'd3);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort ce d%0d", d), mem_ce[d], 1'b0);
      chk($sformatf("abort state d%0d", d), dbg[d], 3'd0);
      chk($sformatf("abort ac d%0d", d), ac[d], 16'd0);
    end
    i_execute = 1'b0;
    m_ac = 16'd0; m_e = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("abort no_done d%0d", d), done_cnt[d], n_issued);
    issue(OP_LDI, 12'd0, 8'hA5);
    chk_acc("after_abort", 16'h00A5, 1'b0);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("total_done d%0d", d), done_cnt[d], n_issued);
      chk($sformatf("stray_outputs d%0d", d), bad_cnt[d], 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
